// File: rtl/selection_credit_if.sv
// Handshake bundle between routing/switch-allocator (master) and the per-input
// selection stage (slave).
interface selection_credit_if #(
    parameter int N        = 5,
    parameter int M        = 3,
    parameter int CREDIT_W = 3
);
    logic [0:N-1]             i_select_neighbor;
    logic [0:N-1][0:M-1][1:0] i_avail_directions;
    logic [0:3][CREDIT_W-1:0] i_credit;
    logic [0:N-1]             i_grant;
    logic [0:N-1][0:N-1]      o_output_req;
    logic [0:N-1]             o_busy;
    logic [0:N-1]             o_error;

    modport master (
        output i_select_neighbor,
        output i_avail_directions,
        output i_credit,
        output i_grant,
        input  o_output_req,
        input  o_busy,
        input  o_error
    );

    modport slave (
        input  i_select_neighbor,
        input  i_avail_directions,
        input  i_credit,
        input  i_grant,
        output o_output_req,
        output o_busy,
        output o_error
    );
endinterface

// File: rtl/selection_credit.sv
// Per-input output-direction selection: picks among routing candidates by
// downstream credit, holds a one-hot port request until granted, re-picks when stalled.
module selection_credit #(
    parameter int N          = 5,
    parameter int M          = 3,
    parameter int CREDIT_W   = 3,
    parameter int WAIT_LIMIT = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    selection_credit_if.slave  bus
);
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } state_t;

    localparam logic [7:0] WC_LAST = 8'(WAIT_LIMIT - 1);

    state_t              state_r [N];
    state_t              state_s [N];
    logic [1:0]          cand0_r [N];
    logic [1:0]          cand0_s [N];
    logic [1:0]          cand1_r [N];
    logic [1:0]          cand1_s [N];
    logic [1:0]          cnt_r   [N];
    logic [1:0]          cnt_s   [N];
    logic                rr_r    [N];
    logic                rr_s    [N];
    logic [7:0]          wc_r    [N];
    logic [7:0]          wc_s    [N];
    logic [0:N-1][0:N-1] req_r;
    logic [0:N-1][0:N-1] req_s;
    logic [0:N-1]        busy_r;
    logic [0:N-1]        busy_s;
    logic [0:N-1]        err_r;
    logic [0:N-1]        err_s;

    // Result {tie, direction}: larger credit wins, a tie falls back to the rr pointer.
    function automatic logic [2:0] pick_dir(input logic [1:0]          c0,
                                            input logic [1:0]          c1,
                                            input logic [CREDIT_W-1:0] cr0,
                                            input logic [CREDIT_W-1:0] cr1,
                                            input logic                rr);
        logic [2:0] res;
        if (cr0 > cr1) begin
            res = {1'b0, c0};
        end else if (cr1 > cr0) begin
            res = {1'b0, c1};
        end else if (rr == 1'b0) begin
            res = {1'b1, c0};
        end else begin
            res = {1'b1, c1};
        end
        return res;
    endfunction

    // Direction code d requests port d+1; the local port is never requested.
    function automatic logic [0:N-1] port_onehot(input logic [1:0] dir);
        logic [0:N-1] v;
        v = '0;
        case (dir)
            2'd0:    v[1] = 1'b1;
            2'd1:    v[2] = 1'b1;
            2'd2:    v[3] = 1'b1;
            2'd3:    v[4] = 1'b1;
            default: v = '0;
        endcase
        return v;
    endfunction

    function automatic logic [1:0] clamp_cnt(input logic [1:0] raw);
        logic [1:0] c;
        if (raw > 2'd2) begin
            c = 2'd2;
        end else begin
            c = raw;
        end
        return c;
    endfunction

    // Next-state and output decode for every input FSM.
    always_comb begin
        logic [2:0] pick_v;
        logic [1:0] cnt_v;
        logic [1:0] a0_v;
        logic [1:0] a1_v;
        pick_v = 3'b000;
        cnt_v  = 2'b00;
        a0_v   = 2'b00;
        a1_v   = 2'b00;
        for (int i = 0; i < N; i++) begin
            state_s[i] = state_r[i];
            cand0_s[i] = cand0_r[i];
            cand1_s[i] = cand1_r[i];
            cnt_s[i]   = cnt_r[i];
            rr_s[i]    = rr_r[i];
            wc_s[i]    = wc_r[i];
            req_s[i]   = req_r[i];
            busy_s[i]  = busy_r[i];
            err_s[i]   = 1'b0;
            pick_v     = 3'b000;
            a0_v       = bus.i_avail_directions[i][0];
            a1_v       = bus.i_avail_directions[i][1];
            cnt_v      = clamp_cnt(bus.i_avail_directions[i][M-1]);
            case (state_r[i])
                ST_IDLE: begin
                    if (bus.i_select_neighbor[i]) begin
                        cand0_s[i] = a0_v;
                        cand1_s[i] = a1_v;
                        cnt_s[i]   = cnt_v;
                        if (cnt_v == 2'd0) begin
                            err_s[i] = 1'b1;
                        end else if (cnt_v == 2'd1) begin
                            state_s[i] = ST_REQ;
                            req_s[i]   = port_onehot(a0_v);
                            busy_s[i]  = 1'b1;
                            wc_s[i]    = 8'd0;
                        end else begin
                            pick_v     = pick_dir(a0_v, a1_v, bus.i_credit[a0_v],
                                                  bus.i_credit[a1_v], rr_r[i]);
                            rr_s[i]    = rr_r[i] ^ pick_v[2];
                            state_s[i] = ST_REQ;
                            req_s[i]   = port_onehot(pick_v[1:0]);
                            busy_s[i]  = 1'b1;
                            wc_s[i]    = 8'd0;
                        end
                    end else begin
                        state_s[i] = ST_IDLE;
                    end
                end
                ST_REQ: begin
                    // A grant always beats a pending re-selection.
                    if (bus.i_grant[i]) begin
                        state_s[i] = ST_IDLE;
                        req_s[i]   = '0;
                        busy_s[i]  = 1'b0;
                        wc_s[i]    = 8'd0;
                    end else if (wc_r[i] == WC_LAST) begin
                        if (cnt_r[i] == 2'd2) begin
                            pick_v   = pick_dir(cand0_r[i], cand1_r[i],
                                                bus.i_credit[cand0_r[i]],
                                                bus.i_credit[cand1_r[i]], rr_r[i]);
                            rr_s[i]  = rr_r[i] ^ pick_v[2];
                            req_s[i] = port_onehot(pick_v[1:0]);
                            wc_s[i]  = 8'd0;
                        end else begin
                            wc_s[i] = wc_r[i];
                        end
                    end else begin
                        wc_s[i] = wc_r[i] + 8'd1;
                    end
                end
                default: begin
                    state_s[i] = ST_IDLE;
                    req_s[i]   = '0;
                    busy_s[i]  = 1'b0;
                    wc_s[i]    = 8'd0;
                end
            endcase
        end
    end

    // State and registered outputs; reset drops any request without a clock.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < N; i++) begin
                state_r[i] <= ST_IDLE;
                cand0_r[i] <= 2'd0;
                cand1_r[i] <= 2'd0;
                cnt_r[i]   <= 2'd0;
                rr_r[i]    <= 1'b0;
                wc_r[i]    <= 8'd0;
            end
            req_r  <= '0;
            busy_r <= '0;
            err_r  <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                state_r[i] <= state_s[i];
                cand0_r[i] <= cand0_s[i];
                cand1_r[i] <= cand1_s[i];
                cnt_r[i]   <= cnt_s[i];
                rr_r[i]    <= rr_s[i];
                wc_r[i]    <= wc_s[i];
            end
            req_r  <= req_s;
            busy_r <= busy_s;
            err_r  <= err_s;
        end
    end

    assign bus.o_output_req = req_r;
    assign bus.o_busy       = busy_r;
    assign bus.o_error      = err_r;

    selection_credit_chk #(.N(N)) u_chk (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (req_r),
        .busy    (busy_r)
    );
endmodule

// Structural invariants of the request outputs.
module selection_credit_chk #(
    parameter int N = 5
) (
    input logic                clk,
    input logic                reset_n,
    input logic [0:N-1][0:N-1] req,
    input logic [0:N-1]        busy
);
    for (genvar g = 0; g < N; g++) begin : g_chk
        a_onehot: assert property (@(posedge clk) disable iff (!reset_n)
            $onehot0(req[g]) && (req[g][0] == 1'b0));
        a_busy: assert property (@(posedge clk) disable iff (!reset_n)
            busy[g] == (req[g] != '0));
    end
endmodule

// File: tb/tb_selection_credit.sv
// Directed self-checking bench for selection_credit.
module tb_selection_credit;
    localparam int N = 5;
    localparam int M = 3;
    localparam int CREDIT_W = 3;
    localparam int WAIT_LIMIT = 8;

    localparam logic [1:0] D_N = 2'd0;
    localparam logic [1:0] D_E = 2'd1;
    localparam logic [1:0] D_S = 2'd2;
    localparam logic [1:0] D_W = 2'd3;

    localparam logic [31:0] P_N  = 32'h08;
    localparam logic [31:0] P_E  = 32'h04;
    localparam logic [31:0] P_S  = 32'h02;
    localparam logic [31:0] P_W  = 32'h01;
    localparam logic [31:0] ZERO = 32'h0;
    localparam logic [31:0] ONE  = 32'h1;

    logic clk;
    logic reset_n;
    int   n_cmp;
    int   n_err;

    selection_credit_if #(.N(N), .M(M), .CREDIT_W(CREDIT_W)) bus ();

    selection_credit #(
        .N(N), .M(M), .CREDIT_W(CREDIT_W), .WAIT_LIMIT(WAIT_LIMIT)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout, required finish");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_cand(input int p, input logic [1:0] c0, input logic [1:0] c1,
                            input logic [1:0] cnt);
        bus.i_avail_directions[p][0] = c0;
        bus.i_avail_directions[p][1] = c1;
        bus.i_avail_directions[p][2] = cnt;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset_n = 1'b0;
        bus.i_select_neighbor  = '0;
        bus.i_avail_directions = '0;
        bus.i_credit           = '0;
        bus.i_grant            = '0;
        tick;
        tick;
        chk("rst_req",  32'(bus.o_output_req), ZERO);
        chk("rst_busy", 32'(bus.o_busy), ZERO);
        chk("rst_err",  32'(bus.o_error), ZERO);
        reset_n = 1'b1;
        tick;

        // Credit choice on input 1: east(5) beats north(1).
        set_cand(1, D_E, D_N, 2'd2);
        bus.i_credit[1] = 3'd5;
        bus.i_credit[0] = 3'd1;
        bus.i_select_neighbor[1] = 1'b1;
        tick;
        chk("cc_req",  32'(bus.o_output_req[1]), P_E);
        chk("cc_busy", 32'(bus.o_busy[1]), ONE);
        bus.i_select_neighbor[1] = 1'b0;
        tick;
        chk("cc_hold", 32'(bus.o_output_req[1]), P_E);
        tick;
        bus.i_grant[1] = 1'b1;
        tick;
        chk("cc_clr",      32'(bus.o_output_req[1]), ZERO);
        chk("cc_busy_clr", 32'(bus.o_busy[1]), ZERO);
        bus.i_grant[1] = 1'b0;

        // Tie alternation on input 0: north then west.
        set_cand(0, D_N, D_W, 2'd2);
        bus.i_credit[0] = 3'd3;
        bus.i_credit[3] = 3'd3;
        bus.i_select_neighbor[0] = 1'b1;
        tick;
        chk("tie1", 32'(bus.o_output_req[0]), P_N);
        bus.i_select_neighbor[0] = 1'b0;
        bus.i_grant[0] = 1'b1;
        tick;
        chk("tie1_clr", 32'(bus.o_output_req[0]), ZERO);
        bus.i_grant[0] = 1'b0;
        bus.i_select_neighbor[0] = 1'b1;
        tick;
        chk("tie2", 32'(bus.o_output_req[0]), P_W);
        bus.i_select_neighbor[0] = 1'b0;
        bus.i_grant[0] = 1'b1;
        tick;
        chk("tie2_clr", 32'(bus.o_output_req[0]), ZERO);
        bus.i_grant[0] = 1'b0;

        // Re-selection on input 3: east moves to south after WAIT_LIMIT cycles.
        bus.i_credit[1] = 3'd4;
        bus.i_credit[2] = 3'd2;
        set_cand(3, D_E, D_S, 2'd2);
        bus.i_select_neighbor[3] = 1'b1;
        tick;
        chk("rs_first", 32'(bus.o_output_req[3]), P_E);
        bus.i_select_neighbor[3] = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            tick;
            if (k == 3) begin
                bus.i_credit[1] = 3'd0;
                bus.i_credit[2] = 3'd6;
            end
        end
        chk("rs_hold", 32'(bus.o_output_req[3]), P_E);
        tick;
        chk("rs_move", 32'(bus.o_output_req[3]), P_S);
        chk("rs_busy", 32'(bus.o_busy[3]), ONE);
        for (int k = 0; k < 8; k++) begin
            tick;
        end
        chk("rs_stay", 32'(bus.o_output_req[3]), P_S);
        bus.i_grant[3] = 1'b1;
        tick;
        chk("rs_clr", 32'(bus.o_output_req[3]), ZERO);
        bus.i_grant[3] = 1'b0;

        // Grant coinciding with the re-selection point on input 2.
        bus.i_credit[1] = 3'd4;
        bus.i_credit[2] = 3'd2;
        set_cand(2, D_E, D_S, 2'd2);
        bus.i_select_neighbor[2] = 1'b1;
        tick;
        chk("gr_first", 32'(bus.o_output_req[2]), P_E);
        bus.i_select_neighbor[2] = 1'b0;
        bus.i_credit[1] = 3'd0;
        bus.i_credit[2] = 3'd6;
        for (int k = 1; k <= 7; k++) begin
            tick;
        end
        chk("gr_hold", 32'(bus.o_output_req[2]), P_E);
        bus.i_grant[2] = 1'b1;
        tick;
        chk("gr_clr",  32'(bus.o_output_req[2]), ZERO);
        chk("gr_busy", 32'(bus.o_busy[2]), ZERO);
        bus.i_grant[2] = 1'b0;
        tick;
        chk("gr_stay", 32'(bus.o_output_req[2]), ZERO);

        // Error on input 4 alongside four single-candidate selects.
        set_cand(0, D_S, D_N, 2'd1);
        set_cand(1, D_W, D_E, 2'd1);
        set_cand(2, D_N, D_S, 2'd1);
        set_cand(3, D_E, D_W, 2'd1);
        set_cand(4, D_N, D_E, 2'd0);
        bus.i_select_neighbor = 5'b11111;
        tick;
        chk("con_req0", 32'(bus.o_output_req[0]), P_S);
        chk("con_req1", 32'(bus.o_output_req[1]), P_W);
        chk("con_req2", 32'(bus.o_output_req[2]), P_N);
        chk("con_req3", 32'(bus.o_output_req[3]), P_E);
        chk("con_req4", 32'(bus.o_output_req[4]), ZERO);
        chk("con_busy", 32'(bus.o_busy), 32'h1E);
        chk("err_on",   32'(bus.o_error), ONE);
        bus.i_select_neighbor = 5'b00000;
        tick;
        chk("err_off", 32'(bus.o_error), ZERO);
        for (int k = 0; k < 12; k++) begin
            tick;
        end
        chk("sat_req0", 32'(bus.o_output_req[0]), P_S);
        chk("sat_req1", 32'(bus.o_output_req[1]), P_W);
        chk("sat_req2", 32'(bus.o_output_req[2]), P_N);
        chk("sat_req3", 32'(bus.o_output_req[3]), P_E);
        bus.i_grant = 5'b11110;
        tick;
        chk("con_clr", 32'(bus.o_output_req), ZERO);
        bus.i_grant = 5'b00000;

        // Asynchronous reset while input 2 holds a request.
        set_cand(2, D_E, D_N, 2'd1);
        bus.i_select_neighbor[2] = 1'b1;
        tick;
        chk("pre_rst", 32'(bus.o_output_req[2]), P_E);
        bus.i_select_neighbor[2] = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_req",  32'(bus.o_output_req[2]), ZERO);
        chk("async_busy", 32'(bus.o_busy[2]), ZERO);
        tick;
        reset_n = 1'b1;
        tick;
        chk("post_req",  32'(bus.o_output_req), ZERO);
        chk("post_busy", 32'(bus.o_busy), ZERO);
        chk("post_err",  32'(bus.o_error), ZERO);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
